// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo
//   Upstream buffer for the FX2LP slave-FIFO writer on EP6. Words from user
//   logic are queued in an on-chip FIFO and presented to the writer in
//   first-word-fall-through form. Packet fill is tracked against PKT_WORDS.
//
// Optional feature (macro USB_TX_FIFO_PKTEND_EN):
//   Compiles in an idle-timeout FSM that asks the writer to pulse PKTEND when
//   a partial packet has been sitting with an empty FIFO for TIMEOUT cycles.
//   Without the macro pkt_end_req is tied low and pkt_end_ack has no effect.
//
// Ports:
//   CLKOUT       system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      word from user logic
//   in_valid     in_data valid
//   in_ready     FIFO can accept a word this cycle
//   out_data     head-of-FIFO word to the writer
//   out_valid    out_data holds a valid word
//   out_ready    writer consumes out_data this cycle
//   level        words stored, including the output register
//   pkt_cnt      words sent in the current packet
//   pkt_end_req  request to the writer to pulse PKTEND
//   pkt_end_ack  writer has issued PKTEND
//
// Timeout FSM states (feature build only):
//   state  | meaning
//   IDLE   | no partial packet waiting on an empty FIFO
//   WAIT   | partial packet, FIFO empty, idle counter running
//   REQ    | pkt_end_req asserted, output held off until ack

module usb_tx_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int PKT_WORDS  = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  CLKOUT,
  input  logic                  rst_n,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           pkt_cnt,
  output logic                  pkt_end_req,
  input  logic                  pkt_end_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  // Storage behind the output register. Because the output register always
  // refills from memory first, memory is non-empty only while the output
  // register is occupied, so it never holds more than DEPTH-1 words and
  // pointer equality alone means empty.
  logic [15:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [15:0]           r_out_data;
  logic                  r_out_valid;
  logic [15:0]           r_pkt_cnt;

  logic                  w_in_ready;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_mem_empty;
  logic                  w_out_free;
  logic                  w_load_mem;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_out_block;
  logic                  w_pkt_end_req;
  logic                  w_pkt_clr;
  logic [LVL_W-1:0]      w_level_nxt;
  logic [15:0]           w_pkt_base;
  logic [15:0]           w_pkt_inc;
  logic [15:0]           w_pkt_nxt;

  assign w_in_ready  = ~r_level[DEPTH_LOG2];
  assign w_wr        = in_valid & w_in_ready;
  assign w_rd        = r_out_valid & ~w_out_block & out_ready;
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  assign w_out_free  = ~r_out_valid | w_rd;
  assign w_load_mem  = w_out_free & ~w_mem_empty;
  // Straight into the output register when nothing older is queued.
  assign w_bypass    = w_out_free & w_mem_empty & w_wr;
  assign w_push      = w_wr & ~w_bypass;
  assign w_pkt_clr   = pkt_end_ack & w_pkt_end_req;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_pkt_base = w_pkt_clr ? 16'd0 : r_pkt_cnt;
    w_pkt_inc  = w_pkt_base + 16'd1;
    w_pkt_nxt  = w_pkt_base;
    if (w_rd) begin
      // The FX2 commits a full packet on its own, so wrap instead of counting on.
      w_pkt_nxt = (w_pkt_inc == 16'(PKT_WORDS)) ? 16'd0 : w_pkt_inc;
    end
  end

  always_ff @(posedge CLKOUT) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_load_mem) begin
        r_rd_ptr    <= r_rd_ptr + DEPTH_LOG2'(1);
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (w_bypass) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end else if (w_rd) begin
        r_out_valid <= 1'b0;
      end
      r_level   <= w_level_nxt;
      r_pkt_cnt <= w_pkt_nxt;
    end
  end

`ifdef USB_TX_FIFO_PKTEND_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_idle_cnt;

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT) begin
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if ((r_pkt_cnt != 16'd0) && (r_level == '0)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_level != '0) begin
          w_state_nxt = S_IDLE;
        end else if (r_idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (pkt_end_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request comes straight off the state register; holding the output off in
  // REQ keeps any newly buffered word out of the packet being committed.
  always_comb begin
    w_pkt_end_req = (r_state == S_REQ);
    w_out_block   = (r_state == S_REQ);
  end
`else
  assign w_pkt_end_req = 1'b0;
  assign w_out_block   = 1'b0;
`endif

  assign in_ready    = w_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid & ~w_out_block;
  assign level       = r_level;
  assign pkt_cnt     = r_pkt_cnt;
  assign pkt_end_req = w_pkt_end_req;

endmodule

// File: tb/tb_usb_tx_fifo.sv
module tb_usb_tx_fifo;

  logic        CLKOUT;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  level;
  logic [15:0] pkt_cnt;
  logic        pkt_end_req;
  logic        pkt_end_ack;

  int n_pass = 0;
  int n_total = 0;

  usb_tx_fifo #(.DEPTH_LOG2(9), .PKT_WORDS(256), .TIMEOUT(16)) dut (
    .CLKOUT      (CLKOUT),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .pkt_cnt     (pkt_cnt),
    .pkt_end_req (pkt_end_req),
    .pkt_end_ack (pkt_end_ack)
  );

  initial begin
    CLKOUT = 1'b0;
    forever #5 CLKOUT = ~CLKOUT;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        ov;
    logic [15:0] od;
    logic [9:0]  lvl;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLKOUT);
    #1;
  endtask

  task automatic apply_reset();
    in_valid    = 1'b0;
    in_data     = 16'h0;
    out_ready   = 1'b0;
    pkt_end_ack = 1'b0;
    rst_n       = 1'b0;
    #10;
    rst_n       = 1'b1;
  endtask

  // Ten words streamed straight through, then the FIFO drains: pkt_cnt=10, level=0.
  task automatic send_ten();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0C00 + i);
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int acc;
    int rd_cnt;
    int wr_cnt;
    int data_err;
    int lvl_err;
    int pc_err;
    int wraps;
    int early;
    logic did_rd;
    logic did_wr;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0;
    out_ready   = 1'b0;
    pkt_end_ack = 1'b0;
    #16;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_pkt_end_req", 32'(pkt_end_req), 32'd0);
    rst_n = 1'b1;
    #10;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic handshake table: inputs for one cycle, expected outputs after the edge.
    tbl[0]  = '{1'b1, 16'hA55A, 1'b0, 1'b1, 16'hA55A, 10'd1, 16'd0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA55A, 10'd1, 16'd0};
    tbl[2]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 16'hA55A, 10'd2, 16'd0};
    tbl[3]  = '{1'b1, 16'h2222, 1'b1, 1'b1, 16'h1111, 10'd2, 16'd1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h2222, 10'd1, 16'd2};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 10'd0, 16'd3};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 10'd0, 16'd3};
    tbl[7]  = '{1'b1, 16'h3333, 1'b1, 1'b1, 16'h3333, 10'd1, 16'd3};
    tbl[8]  = '{1'b1, 16'h4444, 1'b1, 1'b1, 16'h4444, 10'd1, 16'd4};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h4444, 10'd1, 16'd4};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 10'd0, 16'd5};
    for (int i = 0; i < 11; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(tbl[i].pc));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
    end

    // Fill to full, reject one more, read while full, then drain in order.
    apply_reset();
    acc = 0;
    for (int i = 0; i < 512; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      if (in_ready) acc++;
      step();
    end
    chk("full_accepted", 32'(acc), 32'd512);
    chk("full_level", 32'(level), 32'd512);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_data), 32'h0000);
    in_data = 16'hDEAD;
    step();
    chk("full_reject_level", 32'(level), 32'd512);
    in_data   = 16'hBEEF;
    out_ready = 1'b1;
    chk("full_read_head", 32'(out_data), 32'h0000);
    step();
    chk("full_read_level", 32'(level), 32'd511);
    chk("full_read_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    data_err = 0;
    for (int i = 1; i < 512; i++) begin
      if (!out_valid || out_data != 16'(i)) begin
        data_err++;
        if (data_err <= 4) $display("FAIL drain_word%0d: actual=0x%0h valid=%0d required=0x%0h", i, out_data, out_valid, i);
      end
      step();
    end
    n_total++;
    if (data_err == 0) n_pass++;
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Continuous stream: level constant, in order, pkt_cnt wraps every 256 reads.
    apply_reset();
    rd_cnt = 0; wr_cnt = 0; data_err = 0; lvl_err = 0; pc_err = 0; wraps = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      in_data = 16'(wr_cnt);
      did_rd  = out_valid & out_ready;
      did_wr  = in_ready;
      if (did_rd && out_data != 16'(rd_cnt)) data_err++;
      step();
      if (did_wr) wr_cnt++;
      if (did_rd) rd_cnt++;
      if (level != 10'd1) lvl_err++;
      if (pkt_cnt != 16'(rd_cnt % 256)) pc_err++;
      if (did_rd && (rd_cnt % 256) == 0 && pkt_cnt == 16'd0) wraps++;
    end
    chk("stream_reads", 32'(rd_cnt), 32'd999);
    chk("stream_data_errs", 32'(data_err), 32'd0);
    chk("stream_level_errs", 32'(lvl_err), 32'd0);
    chk("stream_pkt_cnt_errs", 32'(pc_err), 32'd0);
    chk("stream_wraps", 32'(wraps), 32'd3);

    // Reset mid-stream with 100 words stored and a partial packet.
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0100 + i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'(16'h0200 + i);
      step();
    end
    chk("mid_level", 32'(level), 32'd100);
    chk("mid_pkt_cnt", 32'(pkt_cnt), 32'd5);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    #9;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    step();
    in_valid = 1'b0;
    chk("mid_next_valid", 32'(out_valid), 32'd1);
    chk("mid_next_data", 32'(out_data), 32'h7777);
    chk("mid_next_level", 32'(level), 32'd1);

`ifdef USB_TX_FIFO_PKTEND_EN
    // Partial packet idles until the timeout, then PKTEND is requested.
    apply_reset();
    send_ten();
    chk("to_drained_level", 32'(level), 32'd0);
    chk("to_drained_pkt_cnt", 32'(pkt_cnt), 32'd10);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (pkt_end_req) early++;
    end
    chk("to_no_early_req", 32'(early), 32'd0);
    step();
    chk("to_req", 32'(pkt_end_req), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h5A5A;
    step();
    in_valid = 1'b0;
    chk("to_req_write_level", 32'(level), 32'd1);
    chk("to_req_out_blocked", 32'(out_valid), 32'd0);
    chk("to_req_held", 32'(pkt_end_req), 32'd1);
    pkt_end_ack = 1'b1;
    step();
    pkt_end_ack = 1'b0;
    chk("to_ack_req", 32'(pkt_end_req), 32'd0);
    chk("to_ack_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("to_ack_out_valid", 32'(out_valid), 32'd1);
    chk("to_ack_out_data", 32'(out_data), 32'h5A5A);
    step();
    chk("to_after_read_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // A word arriving at idle cycle 8 cancels the timeout; it restarts after drain.
    apply_reset();
    send_ten();
    early = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (pkt_end_req) early++;
    end
    in_valid = 1'b1;
    in_data  = 16'h0BAD;
    step();
    in_valid = 1'b0;
    if (pkt_end_req) early++;
    step();
    chk("re_drain_level", 32'(level), 32'd0);
    chk("re_pkt_cnt", 32'(pkt_cnt), 32'd11);
    for (int i = 0; i < 16; i++) begin
      step();
      if (pkt_end_req) early++;
    end
    chk("re_no_early_req", 32'(early), 32'd0);
    step();
    chk("re_req", 32'(pkt_end_req), 32'd1);
    pkt_end_ack = 1'b1;
    step();
    pkt_end_ack = 1'b0;
    chk("re_ack_req", 32'(pkt_end_req), 32'd0);
    chk("re_ack_pkt_cnt", 32'(pkt_cnt), 32'd0);
`else
    // Without the feature a partial packet never raises a request and ack is ignored.
    apply_reset();
    send_ten();
    early = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pkt_end_req) early++;
    end
    chk("nofeat_no_req", 32'(early), 32'd0);
    pkt_end_ack = 1'b1;
    step();
    pkt_end_ack = 1'b0;
    chk("nofeat_ack_ignored", 32'(pkt_cnt), 32'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
